// File: rtl/mux2a1_cuatrobits_fifo_rr_if.sv
// ----------------------------------------------------------------------------
// mux2a1_cuatrobits_fifo_rr_if
// Bundles the two lane push handshakes, the merged output stream and the
// sticky overflow flags of the 2-to-1 lane merger into one interface.
//
// Signals
//   valid_in0 / data_in0   lane 0 push request and word
//   valid_in1 / data_in1   lane 1 push request and word
//   ready0 / ready1        lane FIFO can take a word this cycle
//   valid_out / data_out   merged stream towards the 1-to-2 demux
//   overflow0 / overflow1  sticky dropped-push indicators
//
// Modports
//   master  the producer side (drives pushes, observes status and stream)
//   slave   the merger itself
// ----------------------------------------------------------------------------
interface mux2a1_cuatrobits_fifo_rr_if #(
    parameter int DATA_W = 4
);
    logic              valid_in0;
    logic [DATA_W-1:0] data_in0;
    logic              valid_in1;
    logic [DATA_W-1:0] data_in1;
    logic              ready0;
    logic              ready1;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              overflow0;
    logic              overflow1;

    modport master (
        output valid_in0, data_in0, valid_in1, data_in1,
        input  ready0, ready1, valid_out, data_out, overflow0, overflow1
    );

    modport slave (
        input  valid_in0, data_in0, valid_in1, data_in1,
        output ready0, ready1, valid_out, data_out, overflow0, overflow1
    );
endinterface

// File: rtl/mux2a1_cuatrobits_fifo_rr.sv
// ----------------------------------------------------------------------------
// mux2a1_cuatrobits_fifo_rr
// Merges two DATA_W-bit lanes into a single stream on clk_2f with strict
// alternation lane0, lane1, lane0, ... so a downstream 1-to-2 demux whose
// selector starts at 0 and toggles on every valid word can rebuild both
// lanes. Each lane owns a DEPTH-entry FIFO; the output stalls whenever the
// lane whose turn it is has nothing buffered.
//
// Ports
//   clk_2f    single clock, all state updates on its rising edge
//   reset_L   asynchronous reset, active-low
//   bus       mux2a1_cuatrobits_fifo_rr_if.slave
//             (lane pushes, ready0/1, valid_out/data_out, overflow0/1)
//
// Parameters
//   DATA_W    word width (default 4)
//   DEPTH     entries per lane FIFO, power of 2, >= 2 (default 4)
//
// Configuration macro
//   MUX2A1_HOLD_LAST_EN  when defined, data_out keeps the last popped word
//                        during idle cycles; otherwise it is 0 when idle.
// ----------------------------------------------------------------------------
module mux2a1_cuatrobits_fifo_rr #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                          clk_2f,
    input  logic                          reset_L,
    mux2a1_cuatrobits_fifo_rr_if.slave    bus
);
    localparam int                ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_t;

    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [ADDR_W-1:0] wr_ptr [2];
    logic [ADDR_W-1:0] rd_ptr [2];
    logic [ADDR_W:0]   count [2];
    lane_t             sel;
    logic [1:0]        overflow;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    logic [1:0]        valid_in;
    logic [DATA_W-1:0] data_in [2];
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [DATA_W-1:0] head;

    assign valid_in   = {bus.valid_in1, bus.valid_in0};
    assign data_in[0] = bus.data_in0;
    assign data_in[1] = bus.data_in1;

    // Only the lane whose turn it is may pop, and only if it holds data.
    // A full lane being popped this cycle frees a slot, so it still accepts.
    // ready is forced low while reset is held so nothing is written then.
    always_comb begin
        pop  = '0;
        ready = '0;
        push = '0;
        pop[0] = (sel == LANE0) && (count[0] != '0);
        pop[1] = (sel == LANE1) && (count[1] != '0);
        for (int n = 0; n < 2; n++) begin
            ready[n] = reset_L && ((count[n] < FULL_CNT) || pop[n]);
            push[n]  = valid_in[n] && ready[n];
        end
    end

    assign head = (sel == LANE1) ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];

    // Storage array is kept out of the reset domain; emptiness is tracked
    // by the counts, so stale contents are never observable.
    always_ff @(posedge clk_2f) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem[n][wr_ptr[n]] <= data_in[n];
            end
        end
    end

    // Pointer, count, selector, overflow and output registers. The selector
    // only advances on a pop, never skipping an empty lane, which keeps the
    // lane pairing the downstream demux relies on.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
            sel      <= LANE0;
            overflow <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    wr_ptr[n] <= wr_ptr[n] + PTR_ONE;
                end
                if (pop[n]) begin
                    rd_ptr[n] <= rd_ptr[n] + PTR_ONE;
                end
                count[n] <= count[n] + (push[n] ? CNT_ONE : '0)
                                     - (pop[n]  ? CNT_ONE : '0);
                if (valid_in[n] && !ready[n]) begin
                    overflow[n] <= 1'b1;
                end
            end
            if (|pop) begin
                valid_q <= 1'b1;
                data_q  <= head;
                sel     <= (sel == LANE0) ? LANE1 : LANE0;
            end else begin
                valid_q <= 1'b0;
`ifdef MUX2A1_HOLD_LAST_EN
                data_q  <= data_q;
`else
                data_q  <= '0;
`endif
            end
        end
    end

    assign bus.ready0    = ready[0];
    assign bus.ready1    = ready[1];
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.overflow0 = overflow[0];
    assign bus.overflow1 = overflow[1];

endmodule
